pipestallctl: RTL and testbench
===============================

# pipestallctl

Pipeline stall controller for the 5-stage MIPS32 pipeline. It sequences the multi-cycle divide unit through an IDLE/START/BUSY/DONE state machine and detects load-use hazards in the ID stage. It drives the PC/IF-ID write enable and the ID/EX bubble, and keeps a saturating count of stall cycles for performance monitoring. It sits beside the ID stage, reading EX-stage destination info and ID-stage operand usage.

## Interface
- DIV_CYCLES, 32, divide-unit compute latency in cycles; legal range ≥ 2
- clk  in  1  clock, rising edge
- clr  in  1  reset, synchronous, active-high
- ewreg  in  1  EX-stage instruction writes the register file
- em2reg  in  1  EX-stage instruction is a load
- ern  in  5  EX-stage destination register
- rs, rt  in  5 each  ID-stage source register numbers
- i_rs, i_rt  in  1 each  ID-stage instruction actually reads rs / rt
- id_div  in  1  ID holds div/divu
- id_hilo  in  1  ID holds mfhi/mflo/mthi/mtlo
- wpcir  out  1  write enable for PC and IF/ID (0 = hold)
- drop  out  1  force ID/EX control fields to zero (bubble)
- div_start  out  1  one-cycle pulse; divide unit latches EX operands
- hilo_we  out  1  one-cycle write enable for HI/LO from the divide unit
- mdu_busy  out  1  state ≠ IDLE
- nstall  out  16  saturating count of cycles with stall = 1

## Operation
- loaduse = ewreg & em2reg & (ern ≠ 0) & ((i_rs & ern == rs) | (i_rt & ern == rt)).
- mdustall = (id_div | id_hilo) & (state ≠ IDLE). This includes DONE, so HI/LO readers never see stale data.
- stall = loaduse | mdustall; wpcir = ~stall; drop = stall. All three are combinational.
- issue = id_div & ~stall. A div waiting behind a load-use stall does not issue.
- State machine, register cnt of width clog2(DIV_CYCLES+1):
  - IDLE: if issue → START.
  - START: div_start = 1; cnt ← DIV_CYCLES−1; → BUSY.
  - BUSY: cnt ← cnt−1; if cnt == 1 → DONE.
  - DONE: hilo_we = 1; → IDLE.
- div_start and hilo_we are decoded from the registered state. They are glitch-free and exactly one cycle wide.
- nstall increments when stall = 1 and saturates at 16'hFFFF. Only clr clears it.
- Non-divide instructions keep flowing while BUSY. Only div and HI/LO instructions stall.

## Timing
- Reset (clr = 1 at a rising edge): state = IDLE, cnt = 0, nstall = 0. Consequently div_start = 0, hilo_we = 0, mdu_busy = 0. With idle inputs, wpcir = 1 and drop = 0.
- clr overrides everything, including mid-divide. The in-flight divide is abandoned and hilo_we is never pulsed for it.
- Divide issued (id_div & wpcir) at cycle T:
  - div_start = 1 at T+1.
  - BUSY for cycles T+2 … T+DIV_CYCLES, i.e. DIV_CYCLES−1 cycles.
  - hilo_we = 1 at T+DIV_CYCLES+1.
  - IDLE at T+DIV_CYCLES+2.
- A div or HI/LO instruction in ID during T+1 … T+DIV_CYCLES+1 stalls. It proceeds at T+DIV_CYCLES+2, and a back-to-back div issues that cycle.
- Load-use stall lasts exactly 1 cycle: after the bubble, the load has moved to MEM and loaduse deasserts.
- loaduse and mdustall may be true together; the result is a single stall and nstall increments once per cycle.
- ern = 0 never causes a stall.

## Test plan
- Reset: hold clr = 1 for 2 cycles with random inputs. → mdu_busy = 0, div_start = 0, hilo_we = 0, nstall = 0. After release with inputs at 0, wpcir = 1.
- Load-use: ewreg = 1, em2reg = 1, ern = 5, rs = 5, i_rs = 1. → wpcir = 0, drop = 1, nstall = 1 next cycle. Repeat with ern = 0 → no stall. Repeat with i_rs = 0 → no stall.
- Divide, DIV_CYCLES = 4: id_div = 1 at T. → div_start at T+1, mdu_busy at T+1…T+5, hilo_we at T+5 only, IDLE at T+6.
- Back-to-back: id_div held high from T (DIV_CYCLES = 4). → wpcir = 0 during T+1…T+5, second div_start at T+7, nstall = 5. Add id_hilo = 1 instead of div → same stall window.
- Reset mid-divide: clr = 1 at T+3. → state IDLE at T+4, no hilo_we pulse, wpcir = 1.
- Saturation: force a stall for 65 540 cycles. → nstall holds at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/pipestallctl.sv
// pipestallctl: load-use / divide-unit stall control with stall-cycle counter
module pipestallctl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        i_rs,
    input  logic        i_rt,
    input  logic        id_div,
    input  logic        id_hilo,
    output logic        wpcir,
    output logic        drop,
    output logic        div_start,
    output logic        hilo_we,
    output logic        mdu_busy,
    output logic [15:0] nstall
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_nstall;
    logic          w_loaduse;
    logic          w_mdustall;
    logic          w_stall;
    logic          w_issue;
    // hazard detection: DONE still counts as busy so HI/LO readers wait for the write
    always_comb begin
        w_loaduse  = ewreg & em2reg & (ern != 5'd0) & ((i_rs & (ern == rs)) | (i_rt & (ern == rt)));
        w_mdustall = (id_div | id_hilo) & (r_state != IDLE);
        w_stall    = w_loaduse | w_mdustall;
        w_issue    = id_div & ~w_stall;
        wpcir      = ~w_stall;
        drop       = w_stall;
    end
    // divide sequencer state register; clr abandons any in-flight divide
    always_ff @(posedge clk) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next-state logic
    always_comb begin
        w_next = (r_state == IDLE)  ? (w_issue ? START : IDLE) :
                 (r_state == START) ? BUSY :
                 (r_state == BUSY)  ? ((r_cnt == CW'(1)) ? DONE : BUSY) :
                                      IDLE;
    end
    // latency counter: loaded in START, counts down through BUSY
    always_ff @(posedge clk) begin
        if (clr)                    r_cnt <= '0;
        else if (r_state == START)  r_cnt <= CW'(DIV_CYCLES - 1);
        else if (r_state == BUSY)   r_cnt <= r_cnt - CW'(1);
    end
    // outputs decoded from registered state only, so pulses are clean single cycles
    always_comb begin
        div_start = (r_state == START);
        hilo_we   = (r_state == DONE);
        mdu_busy  = (r_state != IDLE);
    end
    // saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (clr)                               r_nstall <= '0;
        else if (w_stall && r_nstall != 16'hFFFF) r_nstall <= r_nstall + 16'd1;
    end
    assign nstall = r_nstall;
endmodule

// File: tb/tb_pipestallctl.sv
// tb_pipestallctl: scoreboard bench for pipestallctl with DIV_CYCLES = 4
module tb_pipestallctl;
    logic        clk = 1'b0;
    logic        clr, ewreg, em2reg, i_rs, i_rt, id_div, id_hilo;
    logic [4:0]  ern, rs, rt;
    logic        wpcir, drop, div_start, hilo_we, mdu_busy;
    logic [15:0] nstall;
    logic [20:0] q[$];
    logic [20:0] e;
    logic [15:0] ens;
    int          passed = 0;
    int          total  = 0;

    pipestallctl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .clr(clr), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .rs(rs), .rt(rt), .i_rs(i_rs), .i_rt(i_rt), .id_div(id_div),
        .id_hilo(id_hilo), .wpcir(wpcir), .drop(drop), .div_start(div_start),
        .hilo_we(hilo_we), .mdu_busy(mdu_busy), .nstall(nstall)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input logic wp, input logic ds, input logic hw,
                                       input logic bz, input logic [15:0] ns);
        return {wp, ~wp, ds, hw, bz, ns};
    endfunction

    task automatic idle_in();
        {ewreg, em2reg, ern, rs, rt, i_rs, i_rt, id_div, id_hilo} = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        {ewreg, em2reg, ern, rs, rt, i_rs, i_rt, id_div, id_hilo} = 23'($urandom);
        next_cycle();
        {ewreg, em2reg, ern, rs, rt, i_rs, i_rt, id_div, id_hilo} = 23'($urandom);
        q.push_back({2'b00, 19'd0});
        @(negedge clk);
        e = q.pop_front();
        total++;
        if ({2'b00, div_start, hilo_we, mdu_busy, nstall} !== e)
            $display("FAIL reset_hold got=%h exp=%h", {2'b00, div_start, hilo_we, mdu_busy, nstall}, e);
        else passed++;
        next_cycle();
        clr = 1'b0;
        idle_in();
        q.push_back(mk(1, 0, 0, 0, 16'd0));
        @(negedge clk);
        e = q.pop_front();
        total++;
        if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
            $display("FAIL reset_release got=%h exp=%h", {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
        else passed++;
        next_cycle();
        ens = 16'd0;
    endtask

    task automatic test_load_use();
        logic [19:0] tab [8];
        tab[0] = {1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1};
        tab[1] = {1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        tab[2] = {1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0};
        tab[3] = {1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0};
        tab[4] = {1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b1, 1'b1};
        tab[5] = {1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0};
        tab[6] = {1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0};
        tab[7] = {1'b1, 1'b1, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            idle_in();
            {ewreg, em2reg, ern, rs, rt, i_rs, i_rt} = tab[i][19:1];
            q.push_back(mk(~tab[i][0], 0, 0, 0, ens));
            @(negedge clk);
            e = q.pop_front();
            total++;
            if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
                $display("FAIL load_use[%0d] got=%h exp=%h", i, {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
            else passed++;
            next_cycle();
            if (tab[i][0]) ens++;
        end
        idle_in();
    endtask

    task automatic test_divide();
        for (int k = 0; k <= 7; k++) begin
            id_div = (k == 0);
            q.push_back(mk(1, k == 1, k == 5, k >= 1 && k <= 5, ens));
            @(negedge clk);
            e = q.pop_front();
            total++;
            if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
                $display("FAIL divide[%0d] got=%h exp=%h", k, {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
            else passed++;
            next_cycle();
        end
        idle_in();
    endtask

    task automatic test_back_to_back();
        logic bz, wp;
        for (int k = 0; k <= 12; k++) begin
            id_div = (k <= 7);
            bz = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
            wp = ~(id_div & bz);
            q.push_back(mk(wp, k == 1 || k == 7, k == 5 || k == 11, bz, ens));
            @(negedge clk);
            e = q.pop_front();
            total++;
            if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
                $display("FAIL back_to_back[%0d] got=%h exp=%h", k, {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
            else passed++;
            next_cycle();
            if (!wp) ens++;
        end
        for (int k = 0; k <= 7; k++) begin
            id_div  = (k == 0);
            id_hilo = (k >= 1 && k <= 6);
            bz = (k >= 1 && k <= 5);
            wp = ~(id_hilo & bz);
            q.push_back(mk(wp, k == 1, k == 5, bz, ens));
            @(negedge clk);
            e = q.pop_front();
            total++;
            if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
                $display("FAIL hilo_wait[%0d] got=%h exp=%h", k, {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
            else passed++;
            next_cycle();
            if (!wp) ens++;
        end
        idle_in();
    endtask

    task automatic test_reset_mid_divide();
        for (int k = 0; k <= 9; k++) begin
            id_div = (k == 0);
            clr    = (k == 3);
            q.push_back(mk(1, k == 1, 0, k >= 1 && k <= 3, ens));
            @(negedge clk);
            e = q.pop_front();
            total++;
            if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
                $display("FAIL reset_mid_div[%0d] got=%h exp=%h", k, {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
            else passed++;
            next_cycle();
            if (k == 3) ens = 16'd0;
        end
        clr = 1'b0;
        idle_in();
    endtask

    task automatic test_saturation();
        {ewreg, em2reg, ern, rs, i_rs} = {1'b1, 1'b1, 5'd12, 5'd12, 1'b1};
        for (int k = 0; k < 65540; k++) begin
            if (k <= 1 || (k >= 65533 && k <= 65536) || k == 65539) begin
                q.push_back(mk(0, 0, 0, 0, (k < 65535) ? 16'(k) : 16'hFFFF));
                @(negedge clk);
                e = q.pop_front();
                total++;
                if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
                    $display("FAIL saturate[%0d] got=%h exp=%h", k, {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
                else passed++;
            end
            next_cycle();
        end
        idle_in();
        q.push_back(mk(1, 0, 0, 0, 16'hFFFF));
        @(negedge clk);
        e = q.pop_front();
        total++;
        if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
            $display("FAIL saturate_hold got=%h exp=%h", {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
        else passed++;
        next_cycle();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        q.push_back(mk(1, 0, 0, 0, 16'd0));
        @(negedge clk);
        e = q.pop_front();
        total++;
        if ({wpcir, drop, div_start, hilo_we, mdu_busy, nstall} !== e)
            $display("FAIL saturate_clear got=%h exp=%h", {wpcir, drop, div_start, hilo_we, mdu_busy, nstall}, e);
        else passed++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_back_to_back();
        test_reset_mid_divide();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
